uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- Downstream counterpart of uart_transmitter: deserialises the asynchronous serial line back into parallel frames.
- Sits at the far end of a tx wire, or in loopback benches, feeding a consumer that samples data on a one-cycle valid strobe.
- Self-contained bit timing from the native clock; no external baud clock and no backpressure.

Parameters:
- NATIVE_CLK_FREQUENCY, 1000000000, clk frequency in Hz.
- BAUDRATE, 9600, line rate in bits/s.
- FRAME_DATA_LENGTH, 8, data bits per frame.
- Derived (localparam): CLKS_PER_BIT = NATIVE_CLK_FREQUENCY / BAUDRATE (integer division, truncated); HALF_BIT = CLKS_PER_BIT / 2. CLKS_PER_BIT >= 4 required; elaboration error otherwise.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- data  output  [0:FRAME_DATA_LENGTH-1]  last good frame; data[0] is the first data bit on the line.
- data_valid  output  1  one-cycle pulse, data updated this cycle.
- frame_error  output  1  one-cycle pulse, stop bit sampled low.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (reset_n low, async): state IDLE, counters 0, data all zeros, data_valid 0, frame_error 0, synchroniser flops 1.
- Input path: rx passes through a 2-flop synchroniser (rx_s); all decisions use rx_s. Latency: 2 clk.
- Sample point: single-sample mode samples rx_s when the bit counter equals the sample index, where the counter runs 0..CLKS_PER_BIT-1 and wraps.
- IDLE:
  - rx_s 1 to 0 transition (registered previous value) -> START, counter cleared.
  - rx_s held low out of reset does not start a frame; a falling edge is required.
- START:
  - Counter reaches HALF_BIT-1: rx_s low -> DATA, counter cleared, bit index 0.
  - rx_s high -> IDLE (glitch rejected), no pulses.
- DATA:
  - Every time the counter reaches CLKS_PER_BIT-1, sample into the shift register at position bit index; bit index increments.
  - After index FRAME_DATA_LENGTH-1 is sampled -> STOP.
- STOP, counter reaches CLKS_PER_BIT-1:
  - Sample 1: data <= shift register, data_valid = 1 for exactly one cycle -> IDLE.
  - Sample 0: frame_error = 1 for one cycle, data unchanged -> BREAK.
- BREAK: wait until rx_s = 1 -> IDLE. Prevents a held-low line (break condition) from re-triggering.
- Extra stop bits (the transmitter sends two) are absorbed in IDLE, since no falling edge occurs.
- A new start edge is accepted on the cycle after returning to IDLE. No overrun detection: data is overwritten by the next good frame whether or not it was consumed.
- Timing: data_valid asserts (2 + HALF_BIT + (FRAME_DATA_LENGTH+1)*CLKS_PER_BIT) clk after the rx falling edge, ±1.
- reset_n mid-frame: immediate return to reset values; the partial frame is discarded.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- When defined: each bit decision (start check, data bits, stop bit) is the 2-of-3 majority of rx_s sampled at the sample index-1, index, and index+1. The decision is registered at index+1, so all sample points shift one clk later. A single-cycle glitch at a sample point is ignored.
- When undefined: single sample at the index, as in Behaviour.
- Frame format, ports and pulse widths are identical in both builds.

Test Plan:
- Bench parameters for all scenarios: NATIVE_CLK_FREQUENCY=153600, BAUDRATE=9600 (CLKS_PER_BIT=16).
- Loopback: uart_transmitter drives rx and sends 8'b1010_0011 then 8'b0000_0001 -> two data_valid pulses, data equal to each word in order, frame_error never asserted, busy low between frames.
- False start: rx low for 5 clk, then high -> no data_valid, no frame_error, busy returns low within 10 clk.
- Framing error: send 0x5A with stop bit forced 0, hold rx low 40 clk, release -> frame_error pulse once, data keeps the previous value, no restart until rx is high. A following good 0xC3 is received correctly.
- Reset mid-frame: assert reset_n low during data bit 4 of 0xFF, release, then send 0x3C -> outputs zero during reset, next data_valid shows 0x3C, no spurious pulse.
- Back-to-back: 16 frames with one stop bit each, random data -> 16 data_valid pulses, all data matching.
- With UART_RX_MAJORITY_EN defined: 1-clk inverted glitch at each data-bit centre of 0x96 -> data 0x96. Without the macro, the same stimulus corrupts data.

Source files
------------

// File: rtl/uart_receiver.sv
// UART receiver: 2-flop synchronised rx, start-edge detect, mid-bit sampling, 1 stop bit.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority voting around every sample point.
module uart_receiver #(
  parameter int NATIVE_CLK_FREQUENCY = 1000000000,
  parameter int BAUDRATE             = 9600,
  parameter int FRAME_DATA_LENGTH    = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         rx,
  output logic [0:FRAME_DATA_LENGTH-1] data,
  output logic                         data_valid,
  output logic                         frame_error,
  output logic                         busy
);

  localparam int CLKS_PER_BIT = NATIVE_CLK_FREQUENCY / BAUDRATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W        = (FRAME_DATA_LENGTH > 1) ? $clog2(FRAME_DATA_LENGTH) : 1;

`ifdef UART_RX_MAJORITY_EN
  // The vote needs the sample after the centre, so the start check lands one clk
  // later; every data/stop decision then follows one clk after its centre as well.
  localparam int START_IDX = HALF_BIT;
`else
  localparam int START_IDX = HALF_BIT - 1;
`endif

  localparam logic [CNT_W-1:0] START_POINT = CNT_W'(START_IDX);
  localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(FRAME_DATA_LENGTH - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_cfg
    $error("uart_receiver: CLKS_PER_BIT must be at least 4");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                         state;
  logic   [CNT_W-1:0]             cnt;
  logic   [IDX_W-1:0]             bit_idx;
  logic   [0:FRAME_DATA_LENGTH-1] shreg;
  logic                           rx_meta;
  logic                           rx_s;
  logic                           rx_prev;
  logic   [2:0]                   prime;
  logic                           bit_value;
  logic                           start_edge;

`ifdef UART_RX_MAJORITY_EN
  logic rx_d2;
  assign bit_value = (rx_d2 & rx_prev) | (rx_d2 & rx_s) | (rx_prev & rx_s);
`else
  assign bit_value = rx_s;
`endif

  // rx_prev only reflects the real line once the synchroniser has refilled after
  // reset; until then a line held low would look like a falling edge.
  assign start_edge = prime[2] & rx_prev & ~rx_s;
  assign busy       = (state != S_IDLE);

  // NOTE: the synchroniser and history flops reset to the idle line level (1), so
  // leaving reset never fabricates a start edge from a zero reset value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
      rx_d2   <= 1'b1;
`endif
      prime   <= '0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
`ifdef UART_RX_MAJORITY_EN
      rx_d2   <= rx_prev;
`endif
      prime   <= {prime[1:0], 1'b1};
    end
  end

  // NOTE: non-blocking assignments throughout, so every branch reads the state,
  // counters and shift register as they were at the start of the cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      data        <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      unique case (state)
        S_IDLE: begin
          cnt <= '0;
          if (start_edge) state <= S_START;
        end
        S_START: begin
          if (cnt == START_POINT) begin
            cnt <= '0;
            if (!bit_value) begin
              state   <= S_DATA;
              bit_idx <= '0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == LAST_CNT) begin
            cnt            <= '0;
            shreg[bit_idx] <= bit_value;
            if (bit_idx == LAST_IDX) state <= S_STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == LAST_CNT) begin
            cnt <= '0;
            if (bit_value) begin
              data       <= shreg;
              data_valid <= 1'b1;
              state      <= S_IDLE;
            end else begin
              frame_error <= 1'b1;
              state       <= S_BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_BREAK: begin
          // A held-low line must go high before another start edge can count.
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clk per bit; a bench-side transmitter drives rx.
// Expected data is the line order of each byte (data[0] = first bit sent = byte LSB).
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic [0:7] data;
  logic       data_valid;
  logic       frame_error;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int dv_count = 0;
  int fe_count = 0;
  logic [0:7] dv_data[$];

  uart_receiver #(
    .NATIVE_CLK_FREQUENCY(153600),
    .BAUDRATE            (9600),
    .FRAME_DATA_LENGTH   (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx         (rx),
    .data       (data),
    .data_valid (data_valid),
    .frame_error(frame_error),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Pulse observer: counts every high cycle, so a stretched pulse shows up as extra.
  initial begin
    forever begin
      @(negedge clk);
      if (data_valid === 1'b1) begin
        dv_count++;
        dv_data.push_back(data);
      end
      if (frame_error === 1'b1) fe_count++;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [0:7] line_order(input logic [7:0] b);
    logic [0:7] r;
    for (int i = 0; i < 8; i++) r[i] = b[i];
    return r;
  endfunction

  task automatic drive(input logic b, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx = b;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int nstop);
    drive(1'b0, 16);
    for (int i = 0; i < 8; i++) drive(b[i], 16);
    drive(stop, 16 * nstop);
  endtask

  task automatic wait_dv(input int target, input string name);
    int n = 0;
    while (dv_count < target && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (dv_count < target) begin
      errors++;
      $display("FAIL %s timeout: data_valid pulses %0d, required %0d", name, dv_count, target);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h, expected 00", data); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid: got %b, expected 0", data_valid); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_frame_error: got %b, expected 0", frame_error); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    rx = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL held_low_busy: got %b, expected 0", busy); end
    checks++; if (dv_count !== 0 || fe_count !== 0) begin
      errors++; $display("FAIL held_low_pulses: dv %0d fe %0d, expected 0 0", dv_count, fe_count);
    end
    drive(1'b1, 10);
  endtask

  task automatic test_loopback();
    int base_dv = dv_count;
    int base_fe = fe_count;
    logic [0:7] exp[2];
    exp[0] = line_order(8'b1010_0011);
    exp[1] = line_order(8'b0000_0001);
    dv_data.delete();
    send_frame(8'b1010_0011, 1'b1, 2);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL loopback_busy_gap: got %b, expected 0", busy); end
    send_frame(8'b0000_0001, 1'b1, 2);
    wait_dv(base_dv + 2, "loopback");
    checks++; if (dv_count !== base_dv + 2) begin errors++; $display("FAIL loopback_count: got %0d, expected %0d", dv_count - base_dv, 2); end
    for (int i = 0; i < 2; i++) begin
      logic [0:7] got;
      got = (i < dv_data.size()) ? dv_data[i] : 8'hxx;
      checks++;
      if (got !== exp[i]) begin errors++; $display("FAIL loopback_word%0d: got %h, expected %h", i, got, exp[i]); end
    end
    checks++; if (data !== exp[1]) begin errors++; $display("FAIL loopback_hold: got %h, expected %h", data, exp[1]); end
    checks++; if (fe_count !== base_fe) begin errors++; $display("FAIL loopback_frame_error: got %0d, expected 0", fe_count - base_fe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL loopback_busy_end: got %b, expected 0", busy); end
  endtask

  task automatic test_false_start();
    int base_dv = dv_count;
    int base_fe = fe_count;
    int n = 0;
    drive(1'b0, 5);
    drive(1'b1, 1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL false_start_seen: busy %b, expected 1", busy); end
    while (busy === 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL false_start_busy: got %b after 10 clk, expected 0", busy); end
    drive(1'b1, 20);
    checks++; if (dv_count !== base_dv || fe_count !== base_fe) begin
      errors++; $display("FAIL false_start_pulses: dv %0d fe %0d, expected 0 0", dv_count - base_dv, fe_count - base_fe);
    end
    checks++; if (data !== line_order(8'h01)) begin errors++; $display("FAIL false_start_data: got %h, expected %h", data, line_order(8'h01)); end
  endtask

  task automatic test_framing_error();
    int base_dv = dv_count;
    int base_fe = fe_count;
    send_frame(8'h5A, 1'b0, 1);
    drive(1'b0, 40);
    checks++; if (fe_count !== base_fe + 1) begin errors++; $display("FAIL framing_pulse: got %0d, expected 1", fe_count - base_fe); end
    checks++; if (dv_count !== base_dv) begin errors++; $display("FAIL framing_no_valid: got %0d, expected 0", dv_count - base_dv); end
    checks++; if (data !== line_order(8'h01)) begin errors++; $display("FAIL framing_data_kept: got %h, expected %h", data, line_order(8'h01)); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL framing_break_busy: got %b, expected 1", busy); end
    drive(1'b1, 10);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL framing_release: busy %b, expected 0", busy); end
    send_frame(8'hC3, 1'b1, 2);
    wait_dv(base_dv + 1, "framing_recover");
    checks++; if (data !== line_order(8'hC3)) begin errors++; $display("FAIL framing_recover_data: got %h, expected %h", data, line_order(8'hC3)); end
    checks++; if (fe_count !== base_fe + 1) begin errors++; $display("FAIL framing_single_pulse: got %0d, expected 1", fe_count - base_fe); end
  endtask

  task automatic test_reset_mid_frame();
    int base_dv = dv_count;
    int base_fe = fe_count;
    drive(1'b0, 16);
    for (int i = 0; i < 4; i++) drive(1'b1, 16);
    drive(1'b1, 8);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL midreset_data: got %h, expected 00", data); end
    checks++; if (data_valid !== 1'b0 || frame_error !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midreset_flags: dv %b fe %b busy %b, expected 0 0 0", data_valid, frame_error, busy);
    end
    reset_n = 1'b1;
    drive(1'b1, 20);
    checks++; if (dv_count !== base_dv || fe_count !== base_fe) begin
      errors++; $display("FAIL midreset_spurious: dv %0d fe %0d, expected 0 0", dv_count - base_dv, fe_count - base_fe);
    end
    send_frame(8'h3C, 1'b1, 2);
    wait_dv(base_dv + 1, "midreset_next");
    checks++; if (data !== line_order(8'h3C)) begin errors++; $display("FAIL midreset_next_data: got %h, expected %h", data, line_order(8'h3C)); end
    checks++; if (dv_count !== base_dv + 1 || fe_count !== base_fe) begin
      errors++; $display("FAIL midreset_next_pulses: dv %0d fe %0d, expected 1 0", dv_count - base_dv, fe_count - base_fe);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vec[16] = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'h80, 8'h7E, 8'h81,
                            8'h3C, 8'hC3, 8'h0F, 8'hF0, 8'h96, 8'h69, 8'h12, 8'hED};
    int base_dv = dv_count;
    int base_fe = fe_count;
    dv_data.delete();
    for (int i = 0; i < 16; i++) send_frame(vec[i], 1'b1, 1);
    drive(1'b1, 20);
    wait_dv(base_dv + 16, "b2b");
    checks++; if (dv_count !== base_dv + 16) begin errors++; $display("FAIL b2b_count: got %0d, expected 16", dv_count - base_dv); end
    for (int i = 0; i < 16; i++) begin
      logic [0:7] got;
      got = (i < dv_data.size()) ? dv_data[i] : 8'hxx;
      checks++;
      if (got !== line_order(vec[i])) begin
        errors++; $display("FAIL b2b_word%0d: got %h, expected %h", i, got, line_order(vec[i]));
      end
    end
    checks++; if (fe_count !== base_fe) begin errors++; $display("FAIL b2b_frame_error: got %0d, expected 0", fe_count - base_fe); end
  endtask

  // One inverted clk exactly at each data-bit centre: a single sampler reads the
  // inverted bit, a 2-of-3 vote rejects it.
  task automatic test_glitch();
    logic [7:0] b = 8'h96;
    logic [0:7] exp;
    int base_dv = dv_count;
`ifdef UART_RX_MAJORITY_EN
    exp = line_order(8'h96);
`else
    exp = line_order(8'h69);
`endif
    drive(1'b0, 16);
    for (int i = 0; i < 8; i++) begin
      drive(b[i], 8);
      drive(~b[i], 1);
      drive(b[i], 7);
    end
    drive(1'b1, 32);
    wait_dv(base_dv + 1, "glitch");
    checks++; if (data !== exp) begin errors++; $display("FAIL glitch_data: got %h, expected %h", data, exp); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_false_start();
    test_framing_error();
    test_reset_mid_frame();
    test_back_to_back();
    test_glitch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
